// File: rtl/axi_console_sink.sv
// Multi-channel AXI4 character sink: per-channel byte FIFOs fed from AW/W,
// ID-queued B responses, fill-level reads on AR/R and a round-robin drain.
module axi_console_sink #(
   parameter int NumChannels    = 4,
   parameter int ChannelStride  = 32'h100,
   parameter int FifoDepth      = 16,
   parameter int MaxOutstanding = 4,
   parameter int IdWidth        = 6,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   localparam int ChanW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   aw_valid_i,
   output logic                   aw_ready_o,
   input  logic [IdWidth-1:0]     aw_id_i,
   input  logic [AddrWidth-1:0]   aw_addr_i,
   input  logic [7:0]             aw_len_i,
   input  logic                   w_valid_i,
   output logic                   w_ready_o,
   input  logic [DataWidth-1:0]   w_data_i,
   input  logic [DataWidth/8-1:0] w_strb_i,
   input  logic                   w_last_i,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   output logic [IdWidth-1:0]     b_id_o,
   output logic [1:0]             b_resp_o,
   input  logic                   ar_valid_i,
   output logic                   ar_ready_o,
   input  logic [IdWidth-1:0]     ar_id_i,
   input  logic [AddrWidth-1:0]   ar_addr_i,
   output logic                   r_valid_o,
   input  logic                   r_ready_i,
   output logic [IdWidth-1:0]     r_id_o,
   output logic [DataWidth-1:0]   r_data_o,
   output logic [1:0]             r_resp_o,
   output logic                   r_last_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_data_o,
   output logic [ChanW-1:0]       out_chan_o
);
   // state  | meaning
   // S_IDLE | waiting for AW; accepted only while the B queue has room
   // S_DATA | serialising strobed bytes of W beats into the latched channel

   localparam int StrbW    = DataWidth / 8;
   localparam int PtrW     = $clog2(FifoDepth);
   localparam int CntW     = PtrW + 1;
   localparam int StrideSh = $clog2(ChannelStride);
   localparam int BqPtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int BqCntW   = $clog2(MaxOutstanding + 1);

   typedef enum logic {S_IDLE, S_DATA} state_t;

   function automatic logic [ChanW-1:0] chan_of(input logic [AddrWidth-1:0] addr);
      logic [AddrWidth-1:0] sh;
      sh = addr >> StrideSh;
      return sh[ChanW-1:0] & ChanW'(NumChannels - 1);
   endfunction

   logic [7:0]             fifo_mem [NumChannels][FifoDepth];
   logic [PtrW-1:0]        fifo_wr  [NumChannels];
   logic [PtrW-1:0]        fifo_rd  [NumChannels];
   logic [CntW-1:0]        fifo_cnt [NumChannels];
   logic [NumChannels-1:0] fifo_nonempty, push_vec, pop_vec;

   state_t               state_q, state_d;
   logic [IdWidth-1:0]   wid_q;
   logic [ChanW-1:0]     wchan_q;
   logic [StrbW-1:0]     done_q, done_d, remaining, lowest;
   logic [7:0]           push_byte;
   logic                 push_en, chan_full, aw_fire;

   logic [IdWidth-1:0]   bq_mem [MaxOutstanding];
   logic [BqPtrW-1:0]    bq_wr, bq_rd;
   logic [BqCntW-1:0]    bq_cnt;
   logic                 bq_full, bq_push, bq_pop;

   logic [ChanW-1:0]     rr_ptr, grant, lock_chan, idx;
   logic                 locked, found, out_pop;
   logic                 unused_ok;

   assign unused_ok = ^{aw_len_i, aw_addr_i, ar_addr_i};

   // done_q marks lanes of the current beat already pushed; lowest is the next lane
   always_comb begin
      remaining = w_strb_i & ~done_q;
      lowest    = remaining & (~remaining + StrbW'(1));
      push_byte = '0;
      for (int i = StrbW - 1; i >= 0; i--) begin
         if (remaining[i]) push_byte = w_data_i[8*i +: 8];
      end
      chan_full = (fifo_cnt[wchan_q] == CntW'(FifoDepth));
   end

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      push_en    = 1'b0;
      bq_push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            aw_ready_o = !bq_full;
            if (aw_valid_i && !bq_full) state_d = S_DATA;
         end
         S_DATA: begin
            if (w_valid_i) begin
               if (remaining == '0) begin
                  w_ready_o = 1'b1;
               end else if (!chan_full) begin
                  push_en   = 1'b1;
                  done_d    = done_q | lowest;
                  w_ready_o = (remaining == lowest);
               end
               if (w_ready_o) begin
                  done_d = '0;
                  if (w_last_i) begin
                     bq_push = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign aw_fire = (state_q == S_IDLE) && aw_valid_i && !bq_full;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         done_q  <= '0;
         wid_q   <= '0;
         wchan_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (aw_fire) begin
            wid_q   <= aw_id_i;
            wchan_q <= chan_of(aw_addr_i);
         end
      end
   end

   assign bq_full   = (bq_cnt == BqCntW'(MaxOutstanding));
   assign b_valid_o = (bq_cnt != '0);
   assign bq_pop    = b_valid_o && b_ready_i;
   assign b_id_o    = b_valid_o ? bq_mem[bq_rd] : '0;
   assign b_resp_o  = 2'b00;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bq_wr  <= '0;
         bq_rd  <= '0;
         bq_cnt <= '0;
      end else begin
         if (bq_push) bq_wr <= (bq_wr == BqPtrW'(MaxOutstanding - 1)) ? '0 : bq_wr + BqPtrW'(1);
         if (bq_pop)  bq_rd <= (bq_rd == BqPtrW'(MaxOutstanding - 1)) ? '0 : bq_rd + BqPtrW'(1);
         bq_cnt <= bq_cnt + BqCntW'(bq_push) - BqCntW'(bq_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (bq_push) bq_mem[bq_wr] <= wid_q;
   end

   // Grant is frozen while a byte is offered but not taken
   always_comb begin
      grant = rr_ptr;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NumChannels; i++) begin
         idx = ChanW'((int'(rr_ptr) + i) % NumChannels);
         if (!found && fifo_nonempty[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
      if (locked) grant = lock_chan;
   end

   assign out_valid_o = |fifo_nonempty;
   assign out_pop     = out_valid_o && out_ready_i;
   assign out_data_o  = out_valid_o ? fifo_mem[grant][fifo_rd[grant]] : '0;
   assign out_chan_o  = out_valid_o ? grant : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr    <= '0;
         locked    <= 1'b0;
         lock_chan <= '0;
      end else begin
         locked    <= out_valid_o && !out_ready_i;
         lock_chan <= grant;
         if (out_pop) rr_ptr <= ChanW'((int'(grant) + 1) % NumChannels);
      end
   end

   always_comb begin
      for (int c = 0; c < NumChannels; c++) begin
         fifo_nonempty[c] = (fifo_cnt[c] != '0);
         push_vec[c]      = push_en && (wchan_q == ChanW'(c));
         pop_vec[c]       = out_pop && (grant == ChanW'(c));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NumChannels; c++) begin
            fifo_wr[c]  <= '0;
            fifo_rd[c]  <= '0;
            fifo_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NumChannels; c++) begin
            if (push_vec[c]) fifo_wr[c] <= fifo_wr[c] + PtrW'(1);
            if (pop_vec[c])  fifo_rd[c] <= fifo_rd[c] + PtrW'(1);
            fifo_cnt[c] <= fifo_cnt[c] + CntW'(push_vec[c]) - CntW'(pop_vec[c]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NumChannels; c++) begin
         if (push_vec[c]) fifo_mem[c][fifo_wr[c]] <= push_byte;
      end
   end

   assign ar_ready_o = !r_valid_o;
   assign r_resp_o   = 2'b00;
   assign r_last_o   = 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_o <= 1'b0;
         r_id_o    <= '0;
         r_data_o  <= '0;
      end else if (ar_valid_i && ar_ready_o) begin
         r_valid_o <= 1'b1;
         r_id_o    <= ar_id_i;
         r_data_o  <= DataWidth'(fifo_cnt[chan_of(ar_addr_i)]);
      end else if (r_valid_o && r_ready_i) begin
         r_valid_o <= 1'b0;
      end
   end

endmodule
